// File: rtl/ram_io_responder.sv
// Memory-bus responder: program RAM, I/O window at 0x30000,
// UART TX/RX FIFOs and a free-running cycle counter.
module ram_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH_LOG   = 3,
    parameter int RX_DEPTH_LOG   = 3,
    parameter int FULL_MARGIN    = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        prog_stop,
    output logic        tx_overflow
);

    localparam int TXW = TX_DEPTH_LOG + 1;
    localparam int RXW = RX_DEPTH_LOG + 1;
    localparam logic [TXW-1:0] TX_CAP    = TXW'(1 << TX_DEPTH_LOG);
    localparam logic [RXW-1:0] RX_CAP    = RXW'(1 << RX_DEPTH_LOG);
    localparam logic [TXW-1:0] TX_MARGIN = TXW'(FULL_MARGIN);
    localparam logic [17:0]    A_DATA    = 18'h30000;
    localparam logic [17:0]    A_CNT     = 18'h30004;

    logic [7:0] ram [2**RAM_ADDR_WIDTH];
    logic [7:0] ram_q;
    logic [7:0] io_q;
    logic [7:0] io_rdata;
    logic       rd_ram;

    logic [7:0]              tx_mem [1 << TX_DEPTH_LOG];
    logic [TX_DEPTH_LOG-1:0] tx_wp, tx_rp;
    logic [TXW-1:0]          tx_cnt;
    logic [7:0]              rx_mem [1 << RX_DEPTH_LOG];
    logic [RX_DEPTH_LOG-1:0] rx_wp, rx_rp;
    logic [RXW-1:0]          rx_cnt;

    logic [31:0] cycle_cnt;
    logic [31:0] snap;

    logic [17:0]               io_a;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic                      is_io;
    logic                      unused_hi;

    logic rd_data, wr_data, rd_cnt, wr_stop;
    logic tx_push, tx_pop, tx_full, tx_accept;
    logic rx_push, rx_pop;
    logic [7:0] tx_din;

    assign io_a      = mem_a[17:0];
    assign ram_idx   = mem_a[RAM_ADDR_WIDTH-1:0];
    assign is_io     = (mem_a[17:16] == 2'b11);
    assign unused_hi = ^mem_a[31:18];

    assign rd_data = !mem_wr && (io_a == A_DATA);
    assign wr_data =  mem_wr && (io_a == A_DATA);
    assign rd_cnt  = !mem_wr && (io_a == A_CNT);
    assign wr_stop =  mem_wr && (io_a == A_CNT);

    // A zero byte to the data port is ignored; the stop write queues one
    assign tx_push   = (wr_data && (mem_dout != 8'h00)) || wr_stop;
    assign tx_din    = wr_stop ? 8'h00 : mem_dout;
    assign tx_pop    = tx_valid && tx_ready;
    assign tx_full   = (tx_cnt == TX_CAP);
    assign tx_accept = tx_push && (!tx_full || tx_pop);

    assign rx_push = rx_valid && rx_ready;
    assign rx_pop  = rd_data && (rx_cnt != '0);

    assign tx_valid       = (tx_cnt != '0);
    assign tx_data        = tx_valid ? tx_mem[tx_rp] : 8'h00;
    assign rx_ready       = (rx_cnt != RX_CAP);
    assign io_buffer_full = ((TX_CAP - tx_cnt) <= TX_MARGIN);
    assign mem_din        = rd_ram ? ram_q : io_q;

    always_comb begin
        io_rdata = 8'h00;
        case (io_a)
            A_DATA:    io_rdata = (rx_cnt != '0) ? rx_mem[rx_rp] : 8'h00;
            A_CNT:     io_rdata = cycle_cnt[7:0];
            18'h30005: io_rdata = snap[15:8];
            18'h30006: io_rdata = snap[23:16];
            18'h30007: io_rdata = snap[31:24];
            default:   io_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && mem_wr && !is_io) ram[ram_idx] <= mem_dout;
        if (!rst_in && !mem_wr) ram_q <= ram[ram_idx];
    end

    // Read result source is held across write cycles
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_ram <= 1'b0;
            io_q   <= 8'h00;
        end else if (!mem_wr) begin
            rd_ram <= !is_io;
            io_q   <= io_rdata;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && tx_accept) tx_mem[tx_wp] <= tx_din;
        if (!rst_in && rx_push)   rx_mem[rx_wp] <= rx_data;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_accept) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)    tx_rp <= tx_rp + 1'b1;
            tx_cnt <= tx_cnt + TXW'(tx_accept) - TXW'(tx_pop);
            if (rx_push)   rx_wp <= rx_wp + 1'b1;
            if (rx_pop)    rx_rp <= rx_rp + 1'b1;
            rx_cnt <= rx_cnt + RXW'(rx_push) - RXW'(rx_pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cycle_cnt   <= '0;
            snap        <= '0;
            prog_stop   <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (rd_cnt) snap <= cycle_cnt;
            if (wr_stop) prog_stop <= 1'b1;
            if (tx_push && tx_full && !tx_pop) tx_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder with queue-based
// read-data and TX-stream scoreboards.
module tb_ram_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] mem_a = 32'h0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_dout = 8'h0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        prog_stop;
    logic        tx_overflow;

    logic        rd_chk = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  rd_exp_q[$];
    string       rd_nm_q[$];
    logic [7:0]  tx_exp_q[$];

    ram_io_responder dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .mem_a(mem_a),
        .mem_wr(mem_wr),
        .mem_dout(mem_dout),
        .mem_din(mem_din),
        .io_buffer_full(io_buffer_full),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .prog_stop(prog_stop),
        .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        mem_a = a;
        mem_wr = 1'b1;
        mem_dout = d;
        step();
        mem_a = 32'h0;
        mem_wr = 1'b0;
        mem_dout = 8'h0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] e,
                      input string nm);
        rd_exp_q.push_back(e);
        rd_nm_q.push_back(nm);
        mem_a = a;
        mem_wr = 1'b0;
        rd_chk = 1'b1;
        step();
        rd_chk = 1'b0;
        mem_a = 32'h0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_mem_din"}, 32'(mem_din), 32'h0);
        chk({tag, "_tx_valid"}, 32'(tx_valid), 32'h0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'h0);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'h1);
        chk({tag, "_io_full"}, 32'(io_buffer_full), 32'h0);
        chk({tag, "_prog_stop"}, 32'(prog_stop), 32'h0);
        chk({tag, "_tx_ovf"}, 32'(tx_overflow), 32'h0);
    endtask

    // Read-data monitor: a read presented in a cycle is due one edge later
    initial forever begin
        @(negedge clk_in);
        if (rd_chk) begin
            @(posedge clk_in);
            #1;
            if (rd_exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_unexpected: got %0h expected none", mem_din);
            end else begin
                chk(rd_nm_q.pop_front(), 32'(mem_din), 32'(rd_exp_q.pop_front()));
            end
        end
    end

    // TX stream monitor: each accepted handshake pops the next expected byte
    initial forever begin
        @(negedge clk_in);
        if (tx_valid && tx_ready) begin
            if (tx_exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx_unexpected: got %0h expected none", tx_data);
            end else begin
                chk("tx_stream", 32'(tx_data), 32'(tx_exp_q.pop_front()));
            end
        end
    end

    initial begin
        step();
        step();
        chk_reset_outs("rst0");
        rst_in = 1'b0;

        // RAM write then read-back, plus 0x20000 alias
        wr(32'h00010, 8'hA5);
        rd(32'h00010, 8'hA5, "ram_rd");
        rd(32'h20010, 8'hA5, "ram_alias");

        // TX: zero byte ignored, order preserved
        tx_ready = 1'b0;
        wr(32'h30000, 8'h41);
        wr(32'h30000, 8'h00);
        wr(32'h30000, 8'h42);
        tx_exp_q.push_back(8'h41);
        tx_exp_q.push_back(8'h42);
        chk("tx_valid_2", 32'(tx_valid), 32'h1);
        chk("tx_head_41", 32'(tx_data), 32'h41);
        chk("io_full_2", 32'(io_buffer_full), 32'h0);
        tx_ready = 1'b1;
        repeat (4) step();
        chk("tx_drained", 32'(tx_valid), 32'h0);
        chk("tx_q_empty1", 32'(tx_exp_q.size()), 32'h0);

        // RX fill to full, then drain by reads, one past empty
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("rx_ready_%0d", i), 32'(rx_ready), 32'h1);
            rx_data = 8'(i);
            rx_valid = 1'b1;
            step();
        end
        rx_valid = 1'b0;
        chk("rx_ready_full", 32'(rx_ready), 32'h0);
        for (int i = 1; i <= 9; i++)
            rd(32'h30000, (i <= 8) ? 8'(i) : 8'h00, $sformatf("rx_rd_%0d", i));
        chk("rx_ready_empty", 32'(rx_ready), 32'h1);

        // TX threshold, overflow, and push-on-full with simultaneous pop
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr(32'h30000, 8'(8'h10 + i));
            if (i < 8) tx_exp_q.push_back(8'(8'h10 + i));
            if (i == 4) chk("io_full_5", 32'(io_buffer_full), 32'h0);
            if (i == 5) chk("io_full_6", 32'(io_buffer_full), 32'h1);
            if (i == 7) chk("tx_ovf_8", 32'(tx_overflow), 32'h0);
        end
        chk("tx_ovf_9", 32'(tx_overflow), 32'h1);
        tx_ready = 1'b1;
        wr(32'h30000, 8'h19);
        tx_exp_q.push_back(8'h19);
        repeat (10) step();
        chk("tx_q_empty2", 32'(tx_exp_q.size()), 32'h0);
        chk("io_full_drained", 32'(io_buffer_full), 32'h0);

        // Reset clears sticky flags; counter restarts from zero
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("rst1_tx_ovf", 32'(tx_overflow), 32'h0);
        repeat (511) step();
        rd(32'h30004, 8'hFF, "cnt_b0");
        rd(32'h30005, 8'h01, "cnt_b1");
        rd(32'h30006, 8'h00, "cnt_b2");
        rd(32'h30007, 8'h00, "cnt_b3");
        rd(32'h30008, 8'h00, "io_other");

        // Stop write queues a zero byte and sets prog_stop
        tx_ready = 1'b0;
        wr(32'h30004, 8'h77);
        chk("prog_stop", 32'(prog_stop), 32'h1);
        chk("stop_tx_valid", 32'(tx_valid), 32'h1);
        chk("stop_tx_data", 32'(tx_data), 32'h0);

        // Reset during a read and a write: read dropped, write not done
        rd(32'h00010, 8'hA5, "pre_rst_rd");
        mem_a = 32'h00010;
        mem_wr = 1'b0;
        rst_in = 1'b1;
        step();
        tx_exp_q.delete();
        chk_reset_outs("rst2");
        mem_wr = 1'b1;
        mem_dout = 8'h5A;
        step();
        mem_wr = 1'b0;
        mem_dout = 8'h00;
        rst_in = 1'b0;
        rd(32'h00010, 8'hA5, "rst_wr_blocked");

        repeat (3) step();
        chk("rd_q_drained", 32'(rd_exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
